// File: rtl/intpol2_d4_sequencer.sv
// intpol2_d4_sequencer
// Job sequencer for the 2x interpolator core. A host hands over one job
// (samples per frame, bypass, frame count, stall limit); the sequencer then
// starts the core once per frame, counts completed frames, inserts a
// one-cycle gap between frames, reports completion and guards the core with
// a stall watchdog.
//
// Handshake: a job transfers on a rising clk edge where cfg_valid and
// cfg_ready are both 1. cfg_ready is a pure function of state (1 only in
// IDLE), so it never depends on cfg_valid in the same cycle; cfg_* must be
// stable while cfg_valid is 1 and are captured on the transfer edge.
//
// In-cycle priority on every job state: abort, then core_done, then the
// watchdog. core_start and seq_done are decoded from state, so both are
// exactly one cycle wide and go low asynchronously with rst.

module intpol2_d4_sequencer #(
  parameter int CONFIG_WIDTH  = 32,
  parameter int FRAME_WIDTH   = 16,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  // job configuration
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [CONFIG_WIDTH-1:0]  cfg_ilen,
  input  logic                     cfg_bypass,
  input  logic [FRAME_WIDTH-1:0]   cfg_nframes,
  input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
  input  logic                     abort,
  // interpolator core control
  output logic                     core_start,
  output logic                     core_bypass,
  output logic [CONFIG_WIDTH-1:0]  core_ilen,
  // interpolator core status
  input  logic                     core_busy,
  input  logic                     core_done,
  input  logic                     core_stop_empty,
  input  logic                     core_stop_Afull,
  // job status
  output logic [FRAME_WIDTH-1:0]   frame_cnt,
  output logic                     seq_busy,
  output logic                     seq_done,
  output logic                     err_timeout,
  // current FSM state, for checkers and debug
  output logic [2:0]               state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_GAP       = 3'd4,
    S_FINISH    = 3'd5,
    S_ERR       = 3'd6
  } state_t;

  state_t state;
  state_t state_next;

  // latched job configuration
  logic [CONFIG_WIDTH-1:0]  ilen_q;
  logic                     bypass_q;
  logic [FRAME_WIDTH-1:0]   nframes_q;
  logic [TIMEOUT_WIDTH-1:0] timeout_q;

  // watchdog counter: consecutive stalled cycles in the current state
  logic [TIMEOUT_WIDTH-1:0] wd_cnt;

  // decoded events
  logic                     accept;
  logic                     stall;
  logic                     in_watch;
  logic                     wd_hit;
  logic                     frame_last;
  logic [FRAME_WIDTH-1:0]   frame_inc;
  logic [TIMEOUT_WIDTH-1:0] wd_inc;
  logic                     done_take;
  logic                     err_take;

  assign accept     = cfg_valid && (state == S_IDLE);
  assign stall      = core_stop_empty | core_stop_Afull;
  assign in_watch   = (state == S_WAIT_BUSY) || (state == S_RUN);
  assign frame_inc  = frame_cnt + {{(FRAME_WIDTH-1){1'b0}}, 1'b1};
  // nframes == 0 means continuous: no frame is ever the last one
  assign frame_last = (nframes_q != '0) && (frame_inc == nframes_q);
  // saturate so a long stall with the watchdog off can never wrap to a hit
  assign wd_inc     = (wd_cnt == {TIMEOUT_WIDTH{1'b1}}) ? wd_cnt
                      : wd_cnt + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  // the hit fires in the cycle whose stall makes the count reach the limit
  assign wd_hit     = stall && (timeout_q != '0) && (wd_inc == timeout_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode, with abort > core_done > watchdog on every job state
  always_comb begin
    state_next = state;
    done_take  = 1'b0;
    err_take   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = S_START;
        end
      end
      S_START: begin
        state_next = abort ? S_IDLE : S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (core_done) begin
          // zero-length frame: core finished without ever showing busy
          done_take  = 1'b1;
          state_next = frame_last ? S_FINISH : S_GAP;
        end else if (wd_hit) begin
          err_take   = 1'b1;
          state_next = S_ERR;
        end else if (core_busy) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (core_done) begin
          done_take  = 1'b1;
          state_next = frame_last ? S_FINISH : S_GAP;
        end else if (wd_hit) begin
          err_take   = 1'b1;
          state_next = S_ERR;
        end
      end
      S_GAP: begin
        state_next = abort ? S_IDLE : S_START;
      end
      S_FINISH: begin
        state_next = S_IDLE;
      end
      S_ERR: begin
        if (abort) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Job configuration capture; held until the next accepted job
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ilen_q    <= '0;
      bypass_q  <= 1'b0;
      nframes_q <= '0;
      timeout_q <= '0;
    end else if (accept) begin
      ilen_q    <= cfg_ilen;
      bypass_q  <= cfg_bypass;
      nframes_q <= cfg_nframes;
      timeout_q <= cfg_timeout;
    end
  end

  // Frame counter: cleared on accept, bumped on each taken core_done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (accept) begin
      frame_cnt <= '0;
    end else if (done_take) begin
      frame_cnt <= frame_inc;
    end
  end

  // Sticky timeout flag: set on entry to ERR, cleared only by a new job
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_timeout <= 1'b0;
    end else if (accept) begin
      err_timeout <= 1'b0;
    end else if (err_take) begin
      err_timeout <= 1'b1;
    end
  end

  // Watchdog: counts consecutive stalled cycles, restarts on any state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if ((state_next != state) || !in_watch) begin
      wd_cnt <= '0;
    end else if (stall) begin
      wd_cnt <= wd_inc;
    end else begin
      wd_cnt <= '0;
    end
  end

  // Moore outputs decoded from state
  always_comb begin
    cfg_ready  = 1'b0;
    core_start = 1'b0;
    seq_done   = 1'b0;
    seq_busy   = 1'b1;
    case (state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        seq_busy  = 1'b0;
      end
      S_START:  core_start = 1'b1;
      S_FINISH: seq_done   = 1'b1;
      default:  seq_busy   = 1'b1;
    endcase
  end

  assign core_ilen   = ilen_q;
  assign core_bypass = bypass_q;
  assign state_dbg   = state;

endmodule
